// File: rtl/cube_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cube_scan_driver
// Brief    : Double-buffered NxNxN LED cube scanner: row-latch load phase,
//            then PWM-dimmed layer display phase, one layer at a time.
// Revision : 1.0 - initial release
// ============================================================================
module cube_scan_driver #(
    parameter int N        = 8,
    parameter int LOAD_CYC = 4,
    parameter int ON_CYC   = 1024,
    parameter int LW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [LW-1:0] wr_layer,
    input  logic [LW-1:0] wr_row,
    input  logic [N-1:0]  wr_data,
    input  logic          swap_req,
    input  logic [3:0]    brightness,
    output logic          swap_ack,
    output logic          frame_start,
    output logic [N-1:0]  row_data,
    output logic [N-1:0]  row_cs,
    output logic [N-1:0]  layer_en
);

    localparam int              c_cw        = $clog2(ON_CYC > LOAD_CYC ? ON_CYC : LOAD_CYC);
    localparam logic [c_cw-1:0] c_load_last = c_cw'(LOAD_CYC - 1);
    localparam logic [c_cw-1:0] c_show_last = c_cw'(ON_CYC - 1);
    localparam logic [LW-1:0]   c_idx_last  = LW'(N - 1);
    localparam logic [LW:0]     c_n         = (LW + 1)'(N);
    localparam logic [31:0]     c_seg       = 32'(ON_CYC / 16);
    localparam logic [N-1:0]    c_one       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [LW-1:0]   r_layer;
    logic [LW-1:0]   w_layer_nx;
    logic [LW-1:0]   r_row;
    logic [LW-1:0]   w_row_nx;
    logic [c_cw-1:0] r_cyc;
    logic [c_cw-1:0] w_cyc_nx;
    logic [3:0]      r_duty;
    logic            r_front;
    logic            r_pending;
    logic            w_boundary;
    logic            w_swap;
    logic            w_cs_fire;
    logic            w_lit;
    logic            w_wr_ok;

    logic [N-1:0] r_buf [0:1][0:N-1][0:N-1];

    always_comb begin
        w_state_nx = r_state;
        w_layer_nx = r_layer;
        w_row_nx   = r_row;
        w_cyc_nx   = r_cyc + 1'b1;
        w_boundary = 1'b0;
        if (r_state == ST_LOAD) begin
            if (r_cyc == c_load_last) begin
                w_cyc_nx = '0;
                if (r_row == c_idx_last) begin
                    w_row_nx   = '0;
                    w_state_nx = ST_SHOW;
                end else begin
                    w_row_nx = r_row + 1'b1;
                end
            end
        end else begin
            if (r_cyc == c_show_last) begin
                w_cyc_nx   = '0;
                w_state_nx = ST_LOAD;
                if (r_layer == c_idx_last) begin
                    w_layer_nx = '0;
                    w_boundary = 1'b1;
                end else begin
                    w_layer_nx = r_layer + 1'b1;
                end
            end
        end
    end

    assign w_swap    = w_boundary & r_pending;
    assign w_cs_fire = (r_state == ST_LOAD) && (r_cyc == c_load_last);
    // Lit window is (duty+1)/16 of the display phase, starting at its first clock.
    assign w_lit     = (r_state == ST_SHOW) &&
                       ({{(32-c_cw){1'b0}}, r_cyc} < ((32'(r_duty) + 32'd1) * c_seg));
    assign w_wr_ok   = wr_en && ({1'b0, wr_layer} < c_n) && ({1'b0, wr_row} < c_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_layer     <= '0;
            r_row       <= '0;
            r_cyc       <= '0;
            r_duty      <= '0;
            r_front     <= 1'b0;
            r_pending   <= 1'b0;
            row_data    <= '0;
            row_cs      <= '0;
            layer_en    <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_layer   <= w_layer_nx;
            r_row     <= w_row_nx;
            r_cyc     <= w_cyc_nx;
            // A request arriving in the swap cycle itself survives for the next frame.
            r_pending <= swap_req | (r_pending & ~w_swap);
            if (w_swap) begin
                r_front <= ~r_front;
            end
            if ((r_state == ST_LOAD) && (w_state_nx == ST_SHOW)) begin
                r_duty <= brightness;
            end
            row_data    <= (r_state == ST_LOAD) ? r_buf[r_front][r_layer][r_row] : '0;
            row_cs      <= w_cs_fire ? (c_one << r_row) : '0;
            layer_en    <= w_lit ? (c_one << r_layer) : '0;
            swap_ack    <= w_swap;
            frame_start <= (r_state == ST_LOAD) && (r_layer == '0) &&
                           (r_row == '0) && (r_cyc == '0);
        end
    end

    // The back buffer is indexed with the pre-swap select, so a write in the
    // swap cycle lands in the buffer that becomes visible next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        r_buf[b][i][j] <= '0;
                    end
                end
            end
        end else if (w_wr_ok) begin
            r_buf[~r_front][wr_layer][wr_row] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cube_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cube_scan_driver
// Brief    : Self-checking bench for cube_scan_driver (N=8 and N=6 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cube_scan_driver;

    localparam int N       = 8;
    localparam int LC      = 4;
    localparam int OC      = 64;
    localparam int LAYER_T = N * LC + OC;
    localparam int FRAME   = N * LAYER_T;
    localparam int N6      = 6;
    localparam int FRAME6  = N6 * (N6 * LC + OC);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_layer = '0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic [3:0] brightness = '0;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] row_data;
    logic [7:0] row_cs;
    logic [7:0] layer_en;

    logic       reset6 = 1'b1;
    logic       wr_en6 = 1'b0;
    logic [2:0] wr_layer6 = '0;
    logic [2:0] wr_row6 = '0;
    logic [5:0] wr_data6 = '0;
    logic       swap_req6 = 1'b0;
    logic       swap_ack6;
    logic       frame_start6;
    logic [5:0] row_data6;
    logic [5:0] row_cs6;
    logic [5:0] layer_en6;

    cube_scan_driver #(.N(N), .LOAD_CYC(LC), .ON_CYC(OC)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_layer(wr_layer),
        .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req),
        .brightness(brightness), .swap_ack(swap_ack), .frame_start(frame_start),
        .row_data(row_data), .row_cs(row_cs), .layer_en(layer_en)
    );

    cube_scan_driver #(.N(N6), .LOAD_CYC(LC), .ON_CYC(OC)) dut6 (
        .clk(clk), .reset(reset6), .wr_en(wr_en6), .wr_layer(wr_layer6),
        .wr_row(wr_row6), .wr_data(wr_data6), .swap_req(swap_req6),
        .brightness(4'd0), .swap_ack(swap_ack6), .frame_start(frame_start6),
        .row_data(row_data6), .row_cs(row_cs6), .layer_en(layer_en6)
    );

    typedef struct {
        int         cyc;
        logic       fs;
        logic [7:0] cs;
        logic [7:0] en;
    } vec_t;

    vec_t tbl [0:13];

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int acks  = 0;
    int ack_t = -1;
    int mduty = 0;
    bit mpend = 1'b0;
    int lit_cnt [0:15];
    logic [7:0] mfront [0:N-1][0:N-1];
    logic [7:0] mback  [0:N-1][0:N-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t     = 0;
        mpend = 1'b0;
        mduty = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mfront[i][j] = '0;
                mback[i][j]  = '0;
            end
        end
        for (int i = 0; i < 16; i++) lit_cnt[i] = 0;
    endtask

    // Reference: position inside the frame decides every output by arithmetic.
    task automatic step(input bit we, input int wl, input int wr, input logic [7:0] wd,
                        input bit sr, input logic [3:0] br);
        int p, ly, q, rw, k;
        logic [7:0] e_cs, e_en, e_rd, tmp;
        bit e_fs, swp, load;
        p  = t % FRAME;
        ly = p / LAYER_T;
        q  = p % LAYER_T;
        e_fs = (p == 0);
        e_cs = '0;
        e_en = '0;
        e_rd = '0;
        load = (q < N * LC);
        if (load) begin
            rw   = q / LC;
            e_rd = mfront[ly][rw];
            if (q % LC == LC - 1) e_cs = 8'(1 << rw);
        end else begin
            k = q - N * LC;
            if (k < (mduty + 1) * OC / 16) e_en = 8'(1 << ly);
        end
        swp = mpend && (p == FRAME - 1);

        wr_en      = we;
        wr_layer   = 3'(wl);
        wr_row     = 3'(wr);
        wr_data    = wd;
        swap_req   = sr;
        brightness = br;
        @(posedge clk);
        #1;
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("row_cs", 32'(row_cs), 32'(e_cs));
        chk("layer_en", 32'(layer_en), 32'(e_en));
        chk("swap_ack", 32'(swap_ack), 32'(swp));
        if (load) chk("row_data", 32'(row_data), 32'(e_rd));
        if (swap_ack === 1'b1) begin
            acks++;
            ack_t = t;
        end
        if (layer_en != 0 && t / LAYER_T < 16) lit_cnt[t / LAYER_T]++;

        if (q == N * LC - 1) mduty = int'(br);
        if (we && wl < N && wr < N) mback[wl][wr] = wd;
        if (swp) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    tmp          = mfront[i][j];
                    mfront[i][j] = mback[i][j];
                    mback[i][j]  = tmp;
                end
            end
            mpend = sr;
        end else begin
            mpend = mpend | sr;
        end
        t++;
    endtask

    task automatic idle(input logic [3:0] br);
        step(1'b0, 0, 0, 8'h00, 1'b0, br);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_data", 32'(row_data), 32'h0);
        chk("rst_row_cs", 32'(row_cs), 32'h0);
        chk("rst_layer_en", 32'(layer_en), 32'h0);
        chk("rst_swap_ack", 32'(swap_ack), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_table();
        for (int i = 0; i < 14; i++) begin
            while (t < tbl[i].cyc) idle(4'd0);
            idle(4'd0);
            chk("tbl_fs", 32'(frame_start), 32'(tbl[i].fs));
            chk("tbl_cs", 32'(row_cs), 32'(tbl[i].cs));
            chk("tbl_en", 32'(layer_en), 32'(tbl[i].en));
        end
    endtask

    task automatic run_n6();
        bit seen;
        int nz, hit;
        reset6 = 1'b0;
        wr_en6 = 1'b1; wr_layer6 = 3'd7; wr_row6 = 3'd0; wr_data6 = 6'h3F; swap_req6 = 1'b1;
        @(posedge clk); #1;
        wr_layer6 = 3'd1; wr_row6 = 3'd7; wr_data6 = 6'h15; swap_req6 = 1'b0;
        @(posedge clk); #1;
        wr_layer6 = 3'd5; wr_row6 = 3'd5; wr_data6 = 6'h2A;
        @(posedge clk); #1;
        wr_en6 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME6 && !seen; i++) begin
            @(posedge clk); #1;
            if (swap_ack6 === 1'b1) seen = 1'b1;
        end
        chk("n6_ack", 32'(seen), 32'd1);
        nz  = 0;
        hit = 0;
        repeat (FRAME6) begin
            @(posedge clk); #1;
            if (row_data6 == 6'h2A) hit++;
            else if (row_data6 != 6'h00) nz++;
        end
        chk("n6_valid_row", 32'(hit), 32'(LC));
        chk("n6_stray_rows", 32'(nz), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d got=timeout want=finish", t);
        $fatal(1, "watchdog");
    end

    initial begin
        bit we, sr;
        logic [3:0] br;
        int p;

        tbl[0]  = '{0,   1'b1, 8'h00, 8'h00};
        tbl[1]  = '{1,   1'b0, 8'h00, 8'h00};
        tbl[2]  = '{2,   1'b0, 8'h00, 8'h00};
        tbl[3]  = '{3,   1'b0, 8'h01, 8'h00};
        tbl[4]  = '{4,   1'b0, 8'h00, 8'h00};
        tbl[5]  = '{7,   1'b0, 8'h02, 8'h00};
        tbl[6]  = '{31,  1'b0, 8'h80, 8'h00};
        tbl[7]  = '{32,  1'b0, 8'h00, 8'h01};
        tbl[8]  = '{35,  1'b0, 8'h00, 8'h01};
        tbl[9]  = '{36,  1'b0, 8'h00, 8'h00};
        tbl[10] = '{95,  1'b0, 8'h00, 8'h00};
        tbl[11] = '{96,  1'b0, 8'h00, 8'h00};
        tbl[12] = '{99,  1'b0, 8'h01, 8'h00};
        tbl[13] = '{128, 1'b0, 8'h00, 8'h02};

        repeat (3) @(posedge clk);
        #1;
        do_reset();
        run_table();

        // Layer 2 at full brightness, layer 3 sampled at 15 then changed mid-display.
        while (t < 223) idle(4'd0);
        while (t < 320) idle(4'd15);
        while (t <= 330) idle(4'd0);
        chk("lit_layer1_duty0", 32'(lit_cnt[1]), 32'd4);
        chk("lit_layer2_duty15", 32'(lit_cnt[2]), 32'd64);
        chk("pre_rst_layer_en", 32'(layer_en), 32'h08);
        #2 reset = 1'b1;
        #1 chk("async_rst_layer_en", 32'(layer_en), 32'h00);
        do_reset();
        run_table();

        // Single write then swap: shows up one frame later at row slot 2.
        step(1'b1, 0, 2, 8'hA5, 1'b0, 4'd0);
        step(1'b0, 0, 0, 8'h00, 1'b1, 4'd0);
        acks  = 0;
        ack_t = -1;
        while (acks == 0 && t < 3 * FRAME) idle(4'd0);
        chk("ack_seen", 32'(acks), 32'd1);
        chk("ack_pos", 32'(ack_t % FRAME), 32'(FRAME - 1));
        while (t % FRAME != 11) idle(4'd0);
        idle(4'd0);
        chk("a5_row_data", 32'(row_data), 32'hA5);
        chk("a5_row_cs", 32'(row_cs), 32'h04);

        // Three requests in one frame collapse into one swap.
        acks = 0;
        while (t % FRAME != 20) idle(4'd3);
        step(1'b0, 0, 0, 8'h00, 1'b1, 4'd3);
        while (t % FRAME != 300) idle(4'd3);
        step(1'b0, 0, 0, 8'h00, 1'b1, 4'd3);
        while (t % FRAME != 600) idle(4'd3);
        step(1'b0, 0, 0, 8'h00, 1'b1, 4'd3);
        while (t % FRAME != 0) idle(4'd3);
        chk("multi_req_acks", 32'(acks), 32'd1);
        acks = 0;
        repeat (FRAME) idle(4'd3);
        chk("following_frame_acks", 32'(acks), 32'd0);

        // Random traffic; boundary cycles always carry a write and often a request.
        br = 4'd7;
        repeat (4 * FRAME) begin
            p  = t % FRAME;
            we = ($urandom_range(0, 3) == 0);
            sr = ($urandom_range(0, 150) == 0);
            if (p == FRAME - 1) begin
                we = 1'b1;
                sr = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) == 0) br = 4'($urandom);
            step(we, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                 8'($urandom), sr, br);
        end
        wr_en    = 1'b0;
        swap_req = 1'b0;

        run_n6();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
